bcd_stopwatch_counter: RTL and testbench
========================================

Name: bcd_stopwatch_counter

Overview:
- Upstream source for the board's seven-segment digit decoders.
- Converts two raw push-buttons into a start/stop/clear stopwatch.
- Counts 000-999 in BCD at TICK_HZ.
- Presents three 4-bit BCD digits that drive HEX0..HEX2 via the existing digit decode stage (values 0-9 per digit).

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000, clock cycles a synchronized key level must be stable before it is accepted.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_start_n  input  1  raw start/stop button, active-low, asynchronous to clk.
- key_clear_n  input  1  raw clear button, active-low, asynchronous to clk.
- digit0  output  4  BCD units (to HEX0 decoder).
- digit1  output  4  BCD tens (to HEX1 decoder).
- digit2  output  4  BCD hundreds (to HEX2 decoder).
- running  output  1  high while state is RUN.
- wrapped  output  1  sticky flag, set when the count wraps 999->000.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release via normal flops):
  - state IDLE.
  - digit0/1/2 = 0, running = 0, wrapped = 0.
  - Prescaler = 0.
  - Synchronizer and debounced levels = 1 (released).
- Key path, per key:
  - 2-flop synchronizer, then a debounce counter.
  - Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - Press event = one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
  - Latency from a stable key edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles; state changes on the following edge.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 only in RUN; holds its value in PAUSED; is zeroed in IDLE.
  - tick = one-cycle pulse when the prescaler is at its terminal value in RUN; the prescaler returns to 0 on that cycle.
- FSM states IDLE, RUN, PAUSED:
  - IDLE: start press -> RUN.
  - RUN: start press -> PAUSED.
  - PAUSED: start press -> RUN; the prescaler resumes from its held value, so no partial tick is lost.
  - Clear press in any state -> IDLE: digits zeroed, wrapped cleared, prescaler zeroed.
- BCD increment on tick:
  - digit0 +1. At 9, digit0 -> 0 and carries into digit1; same rule from digit1 into digit2.
  - At 999 the count goes to 000 and wrapped is set.
  - Digits never hold values 10-15.
- Simultaneous events, same cycle:
  - Clear and start press: clear wins; state IDLE.
  - Clear and tick: clear wins; no increment.
  - Tick and start press in RUN: increment applied, then PAUSED.
- Outputs are registered; running is decoded from the registered state.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, PAUSED}.
  - BCD_W = 4.
  - BCD_MAX = 4'd9.
- Sub-module key_debounce (synchronizer + debounce counter + press pulse), parameter DEBOUNCE_CYCLES, instantiated twice.
- The FSM, prescaler and BCD chain stay in the top module.

Test Plan:
All scenarios use CLK_HZ=100, TICK_HZ=10 (10 cycles per tick) and DEBOUNCE_CYCLES=4.
1. Reset, then hold key_start_n low for 8 cycles -> running = 1 exactly 7 cycles after the falling edge. After 30 further cycles, digits = 0,0,3 (digit2,digit1,digit0).
2. Key bounce: key_start_n toggles every 2 cycles for 20 cycles, then stays high -> no press pulse; state stays IDLE; digits 000.
3. Pause/resume: run 4 ticks plus 5 cycles, press start -> PAUSED with digits 004. After 100 idle cycles digits are still 004. Press start again -> next tick arrives 5 cycles after re-entering RUN; digits 005.
4. Wrap: run 1000 ticks -> digits 000 and wrapped = 1. Continue 1 tick -> 001 with wrapped still 1. Press clear -> 000, wrapped = 0, running = 0.
5. Simultaneous: align clear and start press pulses on the same cycle while in RUN at 057 -> IDLE, 000. Then align a start press with a tick in RUN at 012 -> PAUSED with 013.
6. Assert rst_n low mid-RUN at 456, asynchronously between clock edges -> outputs go to 0 immediately. After release the block stays IDLE until a start press.

Source files
------------

// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared types and helpers for the BCD stopwatch: FSM states, digit width and
// the three-digit BCD increment used by the count chain.
package bcd_stopwatch_counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] d2;
        logic [BCD_W-1:0] d1;
        logic [BCD_W-1:0] d0;
    } bcd_count_t;

    // True when the count is 999, i.e. the next increment wraps.
    function automatic logic bcd_is_max(input bcd_count_t c);
        return (c.d2 == BCD_MAX) && (c.d1 == BCD_MAX) && (c.d0 == BCD_MAX);
    endfunction

    // Ripple +1 through the three digits; 999 rolls over to 000.
    function automatic bcd_count_t bcd_increment(input bcd_count_t c);
        bcd_count_t n;
        n = c;
        if (c.d0 != BCD_MAX) begin
            n.d0 = c.d0 + BCD_W'(1);
        end else begin
            n.d0 = '0;
            if (c.d1 != BCD_MAX) begin
                n.d1 = c.d1 + BCD_W'(1);
            end else begin
                n.d1 = '0;
                if (c.d2 != BCD_MAX) begin
                    n.d2 = c.d2 + BCD_W'(1);
                end else begin
                    n.d2 = '0;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_key_debounce.sv
// Raw active-low push-button conditioner: 2-flop synchronizer, stability
// counter, and a one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Any cycle where the synchronized level matches the accepted one restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Start/stop/clear stopwatch counting 000-999 in BCD at TICK_HZ; feeds the
// HEX0..HEX2 digit decoders.
module bcd_stopwatch_counter
    import bcd_stopwatch_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start_n,
    input  logic             key_clear_n,
    output logic [BCD_W-1:0] digit0,
    output logic [BCD_W-1:0] digit1,
    output logic [BCD_W-1:0] digit2,
    output logic             running,
    output logic             wrapped
);

    localparam int unsigned PRESC_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic               start_press;
    logic               clear_press;
    logic               tick_c;
    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    bcd_count_t         count_q, count_d;
    logic               wrapped_q, wrapped_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_start_n),
        .press_o (start_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_clear_n),
        .press_o (clear_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign tick_c = (state_q == RUN) && (presc_q == PRESC_LAST);

    // The tick is applied before a same-cycle start press pauses; clear overrides everything.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start_press) state_d = RUN;
            end
            RUN: begin
                presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
                if (tick_c) begin
                    count_d = bcd_increment(count_q);
                    if (bcd_is_max(count_q)) wrapped_d = 1'b1;
                end
                if (start_press) state_d = PAUSED;
            end
            PAUSED: begin
                if (start_press) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
        if (clear_press) begin
            state_d   = IDLE;
            presc_d   = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
        end
    end

    assign digit0  = count_q.d0;
    assign digit1  = count_q.d1;
    assign digit2  = count_q.d2;
    assign running = (state_q == RUN);
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter at 10 cycles/tick, 4-cycle debounce.
module tb_bcd_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_start_n = 1'b1;
    logic        key_clear_n = 1'b1;
    logic [3:0]  digit0, digit1, digit2;
    logic        running, wrapped;
    logic [11:0] digits;
    int          errors = 0;
    int          checks = 0;

    assign digits = {digit2, digit1, digit0};

    always #5 clk = ~clk;

    bcd_stopwatch_counter #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .running     (running),
        .wrapped     (wrapped)
    );

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected keys low until the state change edge (6 cycles to pulse + 1).
    task automatic press_keys(input logic s, input logic c);
        if (s) key_start_n = 1'b0;
        if (c) key_clear_n = 1'b0;
        wait_cycles(7);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
    endtask

    task automatic do_reset();
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        checks++;
        if ({digits, running, wrapped} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state got digits=%h run=%b wrap=%b exp 000/0/0", digits, running, wrapped);
        end
        rst_n = 1'b1;
        wait_cycles(5);
        checks++;
        if ({digits, running, wrapped} !== 14'h0) begin
            errors++;
            $display("FAIL reset_release got digits=%h run=%b wrap=%b exp 000/0/0", digits, running, wrapped);
        end
    endtask

    task automatic test_start_latency();
        do_reset();
        key_start_n = 1'b0;
        wait_cycles(6);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL start_early got run=%b exp 0", running);
        end
        wait_cycles(1);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_at7 got run=%b exp 1", running);
        end
        wait_cycles(1);
        key_start_n = 1'b1;
        wait_cycles(28);
        checks++;
        if (digits !== 12'h002) begin
            errors++;
            $display("FAIL count_before3 got=%h exp=002", digits);
        end
        wait_cycles(1);
        checks++;
        if (digits !== 12'h003 || running !== 1'b1) begin
            errors++;
            $display("FAIL count_3 got=%h run=%b exp=003 run=1", digits, running);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            key_start_n = 1'b0;
            wait_cycles(2);
            key_start_n = 1'b1;
            wait_cycles(2);
            if (running !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_during got %0d running samples exp 0", bad);
        end
        wait_cycles(20);
        checks++;
        if (running !== 1'b0 || digits !== 12'h000) begin
            errors++;
            $display("FAIL bounce_after got run=%b digits=%h exp run=0 digits=000", running, digits);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        press_keys(1'b1, 1'b0);
        wait_cycles(38);
        press_keys(1'b1, 1'b0);
        checks++;
        if (running !== 1'b0 || digits !== 12'h004) begin
            errors++;
            $display("FAIL pause_enter got run=%b digits=%h exp run=0 digits=004", running, digits);
        end
        wait_cycles(100);
        checks++;
        if (running !== 1'b0 || digits !== 12'h004) begin
            errors++;
            $display("FAIL pause_hold got run=%b digits=%h exp run=0 digits=004", running, digits);
        end
        press_keys(1'b1, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL resume_run got run=%b exp 1", running);
        end
        wait_cycles(4);
        checks++;
        if (digits !== 12'h004) begin
            errors++;
            $display("FAIL resume_early got=%h exp=004", digits);
        end
        wait_cycles(1);
        checks++;
        if (digits !== 12'h005) begin
            errors++;
            $display("FAIL resume_tick got=%h exp=005", digits);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press_keys(1'b1, 1'b0);
        wait_cycles(100);
        checks++;
        if (digits !== 12'h010) begin
            errors++;
            $display("FAIL carry_10 got=%h exp=010", digits);
        end
        wait_cycles(900);
        checks++;
        if (digits !== 12'h100) begin
            errors++;
            $display("FAIL carry_100 got=%h exp=100", digits);
        end
        wait_cycles(8999);
        checks++;
        if (digits !== 12'h999 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL at_999 got=%h wrap=%b exp=999 wrap=0", digits, wrapped);
        end
        wait_cycles(1);
        checks++;
        if (digits !== 12'h000 || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_000 got=%h wrap=%b exp=000 wrap=1", digits, wrapped);
        end
        wait_cycles(10);
        checks++;
        if (digits !== 12'h001 || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sticky got=%h wrap=%b exp=001 wrap=1", digits, wrapped);
        end
        press_keys(1'b0, 1'b1);
        checks++;
        if (digits !== 12'h000 || wrapped !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear got=%h wrap=%b run=%b exp=000 wrap=0 run=0", digits, wrapped, running);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_keys(1'b1, 1'b0);
        wait_cycles(570);
        checks++;
        if (digits !== 12'h057) begin
            errors++;
            $display("FAIL sim_pre got=%h exp=057", digits);
        end
        press_keys(1'b1, 1'b1);
        checks++;
        if (running !== 1'b0 || digits !== 12'h000) begin
            errors++;
            $display("FAIL clear_vs_start got run=%b digits=%h exp run=0 digits=000", running, digits);
        end
        wait_cycles(10);
        press_keys(1'b1, 1'b0);
        wait_cycles(123);
        checks++;
        if (running !== 1'b1 || digits !== 12'h012) begin
            errors++;
            $display("FAIL tick_start_pre got run=%b digits=%h exp run=1 digits=012", running, digits);
        end
        press_keys(1'b1, 1'b0);
        checks++;
        if (running !== 1'b0 || digits !== 12'h013) begin
            errors++;
            $display("FAIL tick_vs_start got run=%b digits=%h exp run=0 digits=013", running, digits);
        end
        wait_cycles(20);
        checks++;
        if (digits !== 12'h013) begin
            errors++;
            $display("FAIL tick_vs_start_hold got=%h exp=013", digits);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press_keys(1'b1, 1'b0);
        wait_cycles(4560);
        checks++;
        if (digits !== 12'h456 || running !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got=%h run=%b exp=456 run=1", digits, running);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({digits, running, wrapped} !== 14'h0) begin
            errors++;
            $display("FAIL areset_immediate got digits=%h run=%b wrap=%b exp 000/0/0", digits, running, wrapped);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(30);
        checks++;
        if (running !== 1'b0 || digits !== 12'h000) begin
            errors++;
            $display("FAIL areset_idle got run=%b digits=%h exp run=0 digits=000", running, digits);
        end
        press_keys(1'b1, 1'b0);
        wait_cycles(10);
        checks++;
        if (running !== 1'b1 || digits !== 12'h001) begin
            errors++;
            $display("FAIL areset_restart got run=%b digits=%h exp run=1 digits=001", running, digits);
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_bounce();
        test_pause_resume();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
